beat_packer: RTL
================

Name: beat_packer

Overview:
- Downstream neighbour of the 3-bit valid/ready pipe stage. Consumes its valid/data stream and packs BEATS consecutive beats into one wide word for the next consumer.
- Holds one assembly register and one output register, so it sustains 1 beat/cycle while the downstream consumer keeps ready asserted.
- ready_in depends on registered state only, so there is no combinational path from ready_out to ready_in. This keeps timing separated from the upstream skid stage.
- A last_in marker closes a partial word early.

Parameters:
- DATA_W, 3, width of one input beat.
- BEATS, 4, beats per packed word; must be 2..16.
- OUT_W, DATA_W*BEATS, derived localparam giving the packed word width; not overridable.

Ports:
- sys_clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_in  in  1  upstream beat valid.
- data_in  in  DATA_W  upstream beat data.
- last_in  in  1  qualifies the current beat as the final beat of a word; only meaningful while valid_in is high.
- ready_in  out  1  block can accept a beat this cycle.
- valid_out  out  1  packed word valid.
- data_out  out  OUT_W  packed word; beat k occupies bits [k*DATA_W +: DATA_W].
- beats_out  out  $clog2(BEATS+1)  number of populated lanes in data_out (1..BEATS).
- ready_out  in  1  downstream accepts the word.

Behaviour:
Handshake rules
- Input transfer: valid_in && ready_in. Output transfer: valid_out && ready_out.
- Once valid_out is high, data_out, beats_out and valid_out hold stable until ready_out is sampled high.

Internal state
- asm_data[OUT_W] and asm_cnt (0..BEATS-1): current lane index in the assembly register.
- asm_full: assembly register holds a closed word that is waiting for the output slot.
- out_valid, out_data, out_beats: the output register.

Reset (rst_n low, asynchronous)
- valid_out=0, data_out=0, beats_out=0.
- asm_cnt=0, asm_full=0, asm_data=0.
- ready_in=1 from the first cycle after reset release.
- Reset mid-word discards the partial word silently.

ready_in
- ready_in = !asm_full (registered state only).

Accepted beat
- data_in is written into lane asm_cnt.
- The word closes when asm_cnt==BEATS-1 or last_in=1.

Closing a word
- out_free = !out_valid || ready_out.
- If out_free: the word, with the current beat merged, loads directly into the output register.
  - out_beats = asm_cnt+1.
  - asm_cnt and asm_data clear.
  - Latency from the closing beat to valid_out is 1 cycle.
- Otherwise: asm_full=1, which drops ready_in on the next cycle.

Draining a held word
- While asm_full && out_free, asm_data moves to the output register and asm_full clears.
- ready_in rises in the following cycle.

Output slot
- If an output transfer occurs and no new word loads in the same cycle, valid_out clears.
- A simultaneous output transfer and new-word load keeps valid_out high with the new contents (back-to-back words, no bubble).

Partial words
- Unused upper lanes of data_out are zero.

Ignored inputs
- last_in without valid_in has no effect.
- valid_in while ready_in is low has no effect; data is not sampled.

Throughput and capacity
- With ready_out held high: one beat/cycle sustained, one word every BEATS cycles.
- Worst-case storage is two words (output register plus assembly register).

Optional Feature:
- Macro BEAT_PACKER_STATS_EN.
- When defined, adds two ports:
  - word_cnt (out, 16): increments on each output transfer; wraps at 0xFFFF.
  - stall_cnt (out, 16): increments each cycle valid_out && !ready_out; saturates at 0xFFFF.
  - Both counters reset to 0.
- When undefined, neither port nor the counters exist, and the block behaves identically otherwise.

Decomposition:
- Shared package hs_pkg holds:
  - constant BEAT_W=3, shared with the pipe stage;
  - function clog2 helper;
  - typedef beat_t (logic [BEAT_W-1:0]).
- One sub-module is natural: beat_packer_outreg, the output register slot with valid/hold/load logic. It is reusable by other stages in the handshake family.
- Lane insertion and close detection stay in the top module.

Test Plan:
1. BEATS=4, ready_out=1. Stream 1,2,3,4,5,6,7,0 with no gaps → two words, data_out=12'o4321 then 12'o0765, beats_out=4, valid_out one cycle after beats 4 and 8, ready_in constantly 1.
2. ready_out=0 from start, 9 beats offered continuously → first word in output, second in assembly, ready_in low after beat 8. Raise ready_out → words drain in consecutive cycles; beat 9 accepted the cycle after ready_in returns high.
3. Beats 5,6 with last_in on beat 6 → data_out=12'o0065, beats_out=2; the next word starts at lane 0.
4. Single beat 7 with last_in, ready_out toggling 0,1 → valid_out held with 12'o0007 stable until the ready_out=1 cycle, then cleared.
5. Pulse rst_n low after 2 beats of a word, mid-cycle → all outputs 0 immediately. After release, 4 new beats produce a clean word with no residue from before reset.
6. With BEAT_PACKER_STATS_EN, after scenario 2 → word_cnt=2, stall_cnt equals the number of cycles valid_out was high with ready_out low.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared definitions for the valid/ready handshake family (pipe stage,
// beat packer, ...).
//   BEAT_W : width of one beat on the upstream pipe stage.
//   beat_t : one beat of upstream data.
//   clog2  : constant-foldable ceiling log2, used to size counters/ports.
package hs_pkg;

  localparam int BEAT_W = 3;

  typedef logic [BEAT_W-1:0] beat_t;

  // Ceiling log2; clog2(1) = 0. Only used on elaboration-time constants.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/beat_packer_outreg.sv
// Output register slot for a valid/ready producer.
// Holds one word plus its populated-beat count. A load takes priority over
// an output transfer, so a transfer and a load in the same cycle keep
// valid_out high with the new contents (no bubble). Contents stay stable
// while valid_out && !ready_out.
// Ports:
//   sys_clk, rst_n  clock, asynchronous active-low reset
//   load            write load_data/load_beats into the slot this cycle
//   load_data       word to store
//   load_beats      populated-beat count to store
//   ready_out       downstream accepts the word
//   valid_out       slot holds a word
//   data_out        stored word
//   beats_out       stored beat count
//   out_free        slot is empty or is being emptied this cycle
module beat_packer_outreg #(
  parameter int DATA_W  = 12,
  parameter int BEATS_W = 3
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DATA_W-1:0]  load_data,
  input  logic [BEATS_W-1:0] load_beats,
  input  logic               ready_out,
  output logic               valid_out,
  output logic [DATA_W-1:0]  data_out,
  output logic [BEATS_W-1:0] beats_out,
  output logic               out_free
);

  assign out_free = !valid_out || ready_out;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the data/beat registers are reset as well, because the output
  // ports must read zero during and straight after reset.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      beats_out <= '0;
    end else if (load) begin
      valid_out <= 1'b1;
      data_out  <= load_data;
      beats_out <= load_beats;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: rtl/beat_packer.sv
// beat_packer: packs BEATS consecutive upstream beats into one wide word.
// An assembly register collects beats lane by lane; a closed word goes
// straight into the output slot when it is free, otherwise it parks in the
// assembly register (asm_full) and ready_in drops until it drains.
// ready_in depends on registered state only (no ready_out -> ready_in path).
// last_in on an accepted beat closes a partial word; unused lanes are zero.
// BEATS must be in 2..16.
// Ports:
//   sys_clk, rst_n        clock, asynchronous active-low reset
//   valid_in/data_in      upstream beat
//   last_in               accepted beat is the final beat of its word
//   ready_in              block accepts a beat this cycle
//   valid_out/data_out    packed word, beat k at [k*DATA_W +: DATA_W]
//   beats_out             populated lanes in data_out (1..BEATS)
//   ready_out             downstream accepts the word
// Optional (macro BEAT_PACKER_STATS_EN):
//   word_cnt              output transfers, wraps at 16'hFFFF
//   stall_cnt             cycles with valid_out && !ready_out, saturating
module beat_packer
  import hs_pkg::*;
#(
  parameter int DATA_W = BEAT_W,
  parameter int BEATS  = 4
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         last_in,
  output logic                         ready_in,
  output logic                         valid_out,
  output logic [DATA_W*BEATS-1:0]      data_out,
  output logic [clog2(BEATS+1)-1:0]    beats_out,
  input  logic                         ready_out
`ifdef BEAT_PACKER_STATS_EN
  ,
  output logic [15:0]                  word_cnt,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int OUT_W = DATA_W * BEATS;
  localparam int CNT_W = clog2(BEATS);
  localparam int BO_W  = clog2(BEATS + 1);

  logic [OUT_W-1:0] asm_data;
  logic [CNT_W-1:0] asm_cnt;
  logic             asm_full;

  logic [OUT_W-1:0] merged;
  logic             in_fire;
  logic             close;
  logic             out_free;
  logic             drain;
  logic             load;
  logic [OUT_W-1:0] load_data;
  logic [BO_W-1:0]  load_beats;

  assign ready_in = !asm_full;
  assign in_fire  = valid_in && ready_in;
  assign close    = in_fire && ((asm_cnt == CNT_W'(BEATS - 1)) || last_in);
  assign drain    = asm_full && out_free;

  // Assembly contents with the incoming beat written into lane asm_cnt.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    merged = asm_data;
    for (int k = 0; k < BEATS; k++) begin
      if (asm_cnt == CNT_W'(k)) begin
        merged[k*DATA_W +: DATA_W] = data_in;
      end
    end
  end

  // A parked word keeps asm_cnt at its closing lane, so the beat count is
  // asm_cnt+1 for both a direct load and a drain.
  assign load       = drain || (close && out_free);
  assign load_data  = asm_full ? asm_data : merged;
  assign load_beats = BO_W'(asm_cnt) + BO_W'(1);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_data <= '0;
      asm_cnt  <= '0;
      asm_full <= 1'b0;
    end else if (drain) begin
      asm_data <= '0;
      asm_cnt  <= '0;
      asm_full <= 1'b0;
    end else if (in_fire) begin
      if (close) begin
        if (out_free) begin
          asm_data <= '0;
          asm_cnt  <= '0;
        end else begin
          asm_data <= merged;
          asm_full <= 1'b1;
        end
      end else begin
        asm_data <= merged;
        asm_cnt  <= asm_cnt + CNT_W'(1);
      end
    end
  end

  beat_packer_outreg #(
    .DATA_W  (OUT_W),
    .BEATS_W (BO_W)
  ) u_outreg (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_data  (load_data),
    .load_beats (load_beats),
    .ready_out  (ready_out),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .beats_out  (beats_out),
    .out_free   (out_free)
  );

`ifdef BEAT_PACKER_STATS_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (valid_out && ready_out) begin
        word_cnt <= word_cnt + 16'd1;
      end
      if (valid_out && !ready_out && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
